// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_hs
// Purpose  : Generic pipeline-boundary register with valid/ready handshake,
//            stall and flush. Carries a control bundle and a datapath bundle.
//            With SKID_EN=1 a second (skid) entry lets in_ready be driven
//            from state only, cutting the combinational ready path between
//            stages. With SKID_EN=0 it is a single entry whose in_ready
//            passes out_ready through.
// Ports    : clk        stage clock, rising edge
//            rst_n      asynchronous active-low reset
//            stall      hold the stage (no accept, no emit, state frozen)
//            flush      kill all held and incoming entries
//            in_valid   upstream entry valid
//            in_ready   stage can accept this cycle
//            in_ctrl    upstream control bundle  [CTRL_W]
//            in_data    upstream datapath bundle [DATA_W]
//            out_valid  entry presented downstream
//            out_ready  downstream accepts
//            out_ctrl   control bundle, zero whenever out_valid=0 [CTRL_W]
//            out_data   datapath bundle of the head entry         [DATA_W]
//            occ        number of held entries, 0..2
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_hs #(
  parameter int CTRL_W  = 8,
  parameter int DATA_W  = 101,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  // Occupancy doubles as the control state: EMPTY/ONE/FULL = 0/1/2 entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_m_valid;
  logic [CTRL_W-1:0]   r_m_ctrl;
  logic [DATA_W-1:0]   r_m_data;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_accept;
  logic                w_pop;

  assign w_out_valid = r_m_valid & ~stall & ~flush;
  assign w_pop       = w_out_valid & out_ready;
  assign w_accept    = in_valid & w_in_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  // A bubble must never carry write enables downstream.
  assign out_ctrl  = w_out_valid ? r_m_ctrl : '0;
  assign out_data  = r_m_data;
  assign occ       = r_state;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic              r_s_valid;
      logic [CTRL_W-1:0] r_s_ctrl;
      logic [DATA_W-1:0] r_s_data;

      // Only registered state feeds in_ready; out_ready has no path here.
      assign w_in_ready = ~r_s_valid & ~stall & ~flush;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state   <= ST_EMPTY;
          r_m_valid <= 1'b0;
          r_m_ctrl  <= '0;
          r_m_data  <= '0;
          r_s_valid <= 1'b0;
          r_s_ctrl  <= '0;
          r_s_data  <= '0;
        end else if (flush) begin
          r_state   <= ST_EMPTY;
          r_m_valid <= 1'b0;
          r_m_ctrl  <= '0;
          r_m_data  <= '0;
          r_s_valid <= 1'b0;
          r_s_ctrl  <= '0;
          r_s_data  <= '0;
        end else if (!stall) begin
          case (r_state)
            ST_EMPTY: begin
              if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_ctrl  <= in_ctrl;
                r_m_data  <= in_data;
                r_state   <= ST_ONE;
              end
            end
            ST_ONE: begin
              if (w_accept && w_pop) begin
                r_m_ctrl <= in_ctrl;
                r_m_data <= in_data;
              end else if (w_accept) begin
                // Head is blocked: park the new entry behind it.
                r_s_valid <= 1'b1;
                r_s_ctrl  <= in_ctrl;
                r_s_data  <= in_data;
                r_state   <= ST_FULL;
              end else if (w_pop) begin
                r_m_valid <= 1'b0;
                r_state   <= ST_EMPTY;
              end
            end
            ST_FULL: begin
              if (w_pop) begin
                r_m_ctrl  <= r_s_ctrl;
                r_m_data  <= r_s_data;
                r_s_valid <= 1'b0;
                r_s_ctrl  <= '0;
                r_state   <= ST_ONE;
              end
            end
            default: begin
              // Unreachable encoding: recover to a clean empty stage.
              r_state   <= ST_EMPTY;
              r_m_valid <= 1'b0;
              r_s_valid <= 1'b0;
            end
          endcase
        end
      end
    end else begin : g_single
      // Accept while empty or while the held entry leaves this same cycle.
      assign w_in_ready = (~r_m_valid | out_ready) & ~stall & ~flush;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state   <= ST_EMPTY;
          r_m_valid <= 1'b0;
          r_m_ctrl  <= '0;
          r_m_data  <= '0;
        end else if (flush) begin
          r_state   <= ST_EMPTY;
          r_m_valid <= 1'b0;
          r_m_ctrl  <= '0;
          r_m_data  <= '0;
        end else if (!stall) begin
          if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_ctrl  <= in_ctrl;
            r_m_data  <= in_data;
            r_state   <= ST_ONE;
          end else if (w_pop) begin
            r_m_valid <= 1'b0;
            r_state   <= ST_EMPTY;
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_hs
// Purpose  : Self-checking bench for pipe_stage_hs. Instance u_skid uses
//            SKID_EN=1 (a_* signals), instance u_single uses SKID_EN=0
//            (b_* signals). A queue per instance models the stage as a
//            bounded FIFO (capacity 2 / 1) with stall and flush rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;
  localparam int CW = 8;
  localparam int DW = 101;
  typedef logic [CW+DW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_stall, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic          b_stall, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;

  int n_tests = 0;
  int n_fail  = 0;
  ent_t q1[$];
  ent_t q0[$];

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1)) u_skid (
    .clk(clk), .rst_n(rst_n), .stall(a_stall), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .occ(a_occ)
  );

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(0)) u_single (
    .clk(clk), .rst_n(rst_n), .stall(b_stall), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .occ(b_occ)
  );

  // ---------------- reference model ----------------
  function automatic bit e1_rdy();
    return (q1.size() < 2) && !a_stall && !a_flush;
  endfunction
  function automatic bit e1_vld();
    return (q1.size() != 0) && !a_stall && !a_flush;
  endfunction
  function automatic logic [CW-1:0] e1_ctrl();
    ent_t e;
    if (!e1_vld()) return '0;
    e = q1[0];
    return e[CW+DW-1:DW];
  endfunction
  function automatic bit e0_rdy();
    return ((q0.size() == 0) || b_out_ready) && !b_stall && !b_flush;
  endfunction
  function automatic bit e0_vld();
    return (q0.size() != 0) && !b_stall && !b_flush;
  endfunction
  function automatic logic [CW-1:0] e0_ctrl();
    ent_t e;
    if (!e0_vld()) return '0;
    e = q0[0];
    return e[CW+DW-1:DW];
  endfunction

  // Advance one clock edge and update both models from the inputs in force.
  task automatic tick();
    bit   a_acc, a_pop, b_acc, b_pop;
    ent_t a_new, b_new;
    a_acc = a_in_valid && e1_rdy();
    a_pop = e1_vld() && a_out_ready;
    b_acc = b_in_valid && e0_rdy();
    b_pop = e0_vld() && b_out_ready;
    a_new = {a_in_ctrl, a_in_data};
    b_new = {b_in_ctrl, b_in_data};
    @(posedge clk);
    if (!rst_n) begin
      q1.delete();
      q0.delete();
    end else begin
      if (a_flush) q1.delete();
      else begin
        if (a_pop) void'(q1.pop_front());
        if (a_acc) q1.push_back(a_new);
      end
      if (b_flush) q0.delete();
      else begin
        if (b_pop) void'(q0.pop_front());
        if (b_acc) q0.push_back(b_new);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_stall = 0; a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_in_ctrl = '0; a_in_data = '0;
    b_stall = 0; b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_in_ctrl = '0; b_in_data = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid: got %b want 0", a_out_valid); end
    n_tests++; if (a_out_ctrl !== '0) begin n_fail++; $display("FAIL rst_a_ctrl: got %h want 0", a_out_ctrl); end
    n_tests++; if (a_out_data !== '0) begin n_fail++; $display("FAIL rst_a_data: got %h want 0", a_out_data); end
    n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL rst_a_occ: got %0d want 0", a_occ); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_ready: got %b want 1", a_in_ready); end
    n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid: got %b want 0", b_out_valid); end
    n_tests++; if (b_occ !== 2'd0) begin n_fail++; $display("FAIL rst_b_occ: got %0d want 0", b_occ); end
    n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_ready: got %b want 1", b_in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      a_in_valid = (i < 4); a_in_ctrl = CW'(i + 1); a_in_data = DW'(i + 1);
      b_in_valid = (i < 4); b_in_ctrl = CW'(i + 1); b_in_data = DW'(i + 1);
      #1;
      n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_a_ready[%0d]: got %b want 1", i, a_in_ready); end
      n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_b_ready[%0d]: got %b want 1", i, b_in_ready); end
      n_tests++; if (a_out_valid !== (i > 0)) begin n_fail++; $display("FAIL stream_a_valid[%0d]: got %b want %b", i, a_out_valid, (i > 0)); end
      n_tests++; if (b_out_valid !== (i > 0)) begin n_fail++; $display("FAIL stream_b_valid[%0d]: got %b want %b", i, b_out_valid, (i > 0)); end
      if (i > 0) begin
        n_tests++; if (a_out_data !== DW'(i)) begin n_fail++; $display("FAIL stream_a_data[%0d]: got %h want %h", i, a_out_data, i); end
        n_tests++; if (b_out_data !== DW'(i)) begin n_fail++; $display("FAIL stream_b_data[%0d]: got %h want %h", i, b_out_data, i); end
        n_tests++; if (a_occ !== 2'd1) begin n_fail++; $display("FAIL stream_a_occ[%0d]: got %0d want 1", i, a_occ); end
        n_tests++; if (b_occ !== 2'd1) begin n_fail++; $display("FAIL stream_b_occ[%0d]: got %0d want 1", i, b_occ); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] exp_seq[3];
    logic [DW-1:0] got[$];
    idle_inputs();
    exp_seq[0] = DW'('hA); exp_seq[1] = DW'('hB); exp_seq[2] = DW'('hC);
    a_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1; a_in_ctrl = CW'(exp_seq[i]); a_in_data = exp_seq[i];
      #1;
      n_tests++; if (a_in_ready !== (i < 2)) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", i, a_in_ready, (i < 2)); end
      if (i > 0) begin
        n_tests++; if (a_out_data !== exp_seq[0]) begin n_fail++; $display("FAIL bp_head[%0d]: got %h want %h", i, a_out_data, exp_seq[0]); end
        n_tests++; if (a_occ !== 2'(i)) begin n_fail++; $display("FAIL bp_occ[%0d]: got %0d want %0d", i, a_occ, i); end
      end
      tick();
    end
    #1;
    n_tests++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL bp_full_occ: got %0d want 2", a_occ); end
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", a_in_ready); end
    tick();
    a_out_ready = 1;
    for (int c = 0; c < 10 && (got.size() < 3 || a_in_valid); c++) begin
      bit acc;
      #1;
      if (a_out_valid && a_out_ready) got.push_back(a_out_data);
      acc = a_in_valid && a_in_ready;
      tick();
      if (acc) a_in_valid = 0;
    end
    n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_tests++; if (got[i] !== exp_seq[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], exp_seq[i]); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    a_out_ready = 0;
    a_in_valid = 1; a_in_ctrl = 8'h11; a_in_data = DW'('h11);
    tick();
    a_in_ctrl = 8'h22; a_in_data = DW'('h22);
    tick();
    #1;
    n_tests++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 2", a_occ); end
    a_flush = 1; a_in_valid = 1; a_in_ctrl = 8'hFF; a_in_data = DW'('hFF);
    #1;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", a_out_valid); end
    n_tests++; if (a_out_ctrl !== '0) begin n_fail++; $display("FAIL flush_ctrl: got %h want 0", a_out_ctrl); end
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", a_in_ready); end
    tick();
    a_flush = 0; a_in_valid = 0;
    #1;
    n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", a_occ); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b want 1", a_in_ready); end
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_after: got %b want 0", a_out_valid); end
    n_tests++; if (a_out_data !== '0) begin n_fail++; $display("FAIL flush_data_after: got %h want 0", a_out_data); end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall();
    int seen;
    idle_inputs();
    a_out_ready = 0;
    a_in_valid = 1; a_in_ctrl = 8'h55; a_in_data = DW'('h55);
    tick();
    a_in_valid = 0; a_out_ready = 1; a_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 0", i, a_out_valid); end
      n_tests++; if (a_out_ctrl !== '0) begin n_fail++; $display("FAIL stall_ctrl[%0d]: got %h want 0", i, a_out_ctrl); end
      n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", i, a_in_ready); end
      n_tests++; if (a_occ !== 2'd1) begin n_fail++; $display("FAIL stall_occ[%0d]: got %0d want 1", i, a_occ); end
      tick();
    end
    a_stall = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (a_out_valid && a_out_ctrl == 8'h55) seen++;
      tick();
    end
    n_tests++; if (seen != 1) begin n_fail++; $display("FAIL stall_emit_once: got %0d want 1", seen); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    a_out_ready = 0;
    a_in_valid = 1; a_in_ctrl = 8'h31; a_in_data = DW'('h31);
    tick();
    a_in_ctrl = 8'h32; a_in_data = DW'('h32);
    tick();
    a_in_valid = 0;
    #1;
    n_tests++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL areset_pre_occ: got %0d want 2", a_occ); end
    #1;
    rst_n = 1'b0;
    q1.delete();
    q0.delete();
    #1;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", a_out_valid); end
    n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL areset_occ: got %0d want 0", a_occ); end
    tick();
    rst_n = 1'b1;
    a_out_ready = 1; a_in_valid = 1; a_in_ctrl = 8'h77; a_in_data = DW'('h77);
    #1;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_post_valid0: got %b want 0", a_out_valid); end
    tick();
    a_in_valid = 0;
    #1;
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_post_valid1: got %b want 1", a_out_valid); end
    n_tests++; if (a_out_data !== DW'('h77)) begin n_fail++; $display("FAIL areset_post_data: got %h want 77", a_out_data); end
    tick();
    idle_inputs();
  endtask

  task automatic test_passthrough();
    idle_inputs();
    b_out_ready = 0;
    b_in_valid = 1; b_in_ctrl = 8'h5A; b_in_data = DW'('h5A);
    tick();
    b_in_ctrl = 8'hA5; b_in_data = DW'('hA5);
    #1;
    n_tests++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL pt_ready_blocked: got %b want 0", b_in_ready); end
    n_tests++; if (b_occ !== 2'd1) begin n_fail++; $display("FAIL pt_occ_blocked: got %0d want 1", b_occ); end
    b_out_ready = 1;
    #1;
    n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL pt_ready_open: got %b want 1", b_in_ready); end
    n_tests++; if (b_out_data !== DW'('h5A)) begin n_fail++; $display("FAIL pt_head: got %h want 5a", b_out_data); end
    tick();
    b_in_valid = 0;
    #1;
    n_tests++; if (b_occ !== 2'd1) begin n_fail++; $display("FAIL pt_occ_after: got %0d want 1", b_occ); end
    n_tests++; if (b_out_data !== DW'('hA5)) begin n_fail++; $display("FAIL pt_next: got %h want a5", b_out_data); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    ent_t h;
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      // First phase is a clean back-to-back stream, then full randomisation.
      bit quiet;
      quiet = (c < 60);
      a_in_valid  = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
      a_out_ready = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
      a_stall     = quiet ? 1'b0 : ($urandom_range(0, 9) == 0);
      a_flush     = quiet ? 1'b0 : ($urandom_range(0, 24) == 0);
      a_in_ctrl   = CW'($urandom);
      a_in_data   = DW'({$urandom, $urandom, $urandom, $urandom});
      b_in_valid  = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
      b_out_ready = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
      b_stall     = quiet ? 1'b0 : ($urandom_range(0, 9) == 0);
      b_flush     = quiet ? 1'b0 : ($urandom_range(0, 24) == 0);
      b_in_ctrl   = CW'($urandom);
      b_in_data   = DW'({$urandom, $urandom, $urandom, $urandom});
      #1;
      n_tests++; if (a_in_ready !== e1_rdy()) begin n_fail++; $display("FAIL rnd_a_ready[%0d]: got %b want %b", c, a_in_ready, e1_rdy()); end
      n_tests++; if (a_out_valid !== e1_vld()) begin n_fail++; $display("FAIL rnd_a_valid[%0d]: got %b want %b", c, a_out_valid, e1_vld()); end
      n_tests++; if (a_out_ctrl !== e1_ctrl()) begin n_fail++; $display("FAIL rnd_a_ctrl[%0d]: got %h want %h", c, a_out_ctrl, e1_ctrl()); end
      n_tests++; if (a_occ !== 2'(q1.size())) begin n_fail++; $display("FAIL rnd_a_occ[%0d]: got %0d want %0d", c, a_occ, q1.size()); end
      if (q1.size() != 0) begin
        h = q1[0];
        n_tests++; if (a_out_data !== h[DW-1:0]) begin n_fail++; $display("FAIL rnd_a_data[%0d]: got %h want %h", c, a_out_data, h[DW-1:0]); end
      end
      n_tests++; if (b_in_ready !== e0_rdy()) begin n_fail++; $display("FAIL rnd_b_ready[%0d]: got %b want %b", c, b_in_ready, e0_rdy()); end
      n_tests++; if (b_out_valid !== e0_vld()) begin n_fail++; $display("FAIL rnd_b_valid[%0d]: got %b want %b", c, b_out_valid, e0_vld()); end
      n_tests++; if (b_out_ctrl !== e0_ctrl()) begin n_fail++; $display("FAIL rnd_b_ctrl[%0d]: got %h want %h", c, b_out_ctrl, e0_ctrl()); end
      n_tests++; if (b_occ !== 2'(q0.size())) begin n_fail++; $display("FAIL rnd_b_occ[%0d]: got %0d want %0d", c, b_occ, q0.size()); end
      if (q0.size() != 0) begin
        h = q0[0];
        n_tests++; if (b_out_data !== h[DW-1:0]) begin n_fail++; $display("FAIL rnd_b_data[%0d]: got %h want %h", c, b_out_data, h[DW-1:0]); end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_stall();
    test_async_reset();
    test_passthrough();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Generic pipeline-boundary register for the RISC-V core. It replaces the fixed per-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one parametrised block.
- Carries a control field and a datapath field with a valid/ready handshake, plus the existing `stall` and `flush` controls.
- Optional 2-entry skid mode breaks the combinational ready path between stages when memory or multi-cycle units back-pressure.

Parameters:
- `CTRL_W`, default 8: width of the control bundle (reg_wr, mem_wr, mem_rd, mem_mask, sel_wb, ...).
- `DATA_W`, default 101: width of the datapath bundle (alu_o, wr_data, rd, PC4, ...).
- `SKID_EN`, default 1:
  - 1: 2-entry skid buffer with registered `in_ready`.
  - 0: single entry with pass-through `in_ready`.

Ports:
- `clk`  in  1  stage clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  hold the stage: no accept, no emit, state frozen.
- `flush`  in  1  kill all held and incoming entries.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `in_data`  in  DATA_W  upstream datapath bundle.
- `out_valid`  out  1  entry presented downstream.
- `out_ready`  in  1  downstream accepts.
- `out_ctrl`  out  CTRL_W  control bundle; zero whenever `out_valid`=0.
- `out_data`  out  DATA_W  datapath bundle of the head entry.
- `occ`  out  2  number of held entries, 0..2.

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - Both entries invalid; ctrl/data registers cleared to 0.
  - Outputs: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occ`=0.
  - `in_ready`=1 if `SKID_EN`=1, and also 1 in single-entry mode since the stage is empty.
- Reset mid-operation discards all entries with no further output.
- Storage:
  - main entry `{m_valid, m_ctrl, m_data}` = head of the stage.
  - skid entry `{s_valid, s_ctrl, s_data}`, present only when `SKID_EN`=1.
- Handshake terms:
  - `accept` = `in_valid & in_ready`.
  - `pop` = `out_valid & out_ready`.
  - Latency is 1 cycle: an entry accepted at edge N is visible at the outputs after edge N.
- Output masking:
  - `out_valid` = `m_valid & ~stall & ~flush`.
  - `out_ctrl` = `out_valid ? m_ctrl : 0`, so a bubble never carries reg_wr/mem_wr.
  - `out_data` = `m_data` unmasked.
- Stall (`stall`=1, `flush`=0):
  - `in_ready`=0 and `out_valid`=0; all registers hold.
- Flush (highest priority after reset):
  - `in_ready`=0 and `out_valid`=0 that cycle.
  - Next edge: `m_valid`=`s_valid`=0, ctrl fields cleared to 0; data fields don't-care but cleared to 0.
  - An `in_valid` entry presented in the flush cycle is dropped.
  - `flush` and `stall` together: flush wins.
- `SKID_EN`=1:
  - `in_ready` = `~s_valid & ~stall & ~flush`. `s_valid` is the only state term in it, with no combinational path from `out_ready`.
  - States by `occ`: EMPTY(0), ONE(1), FULL(2). Transitions:
    - EMPTY: accept -> main<=in, ONE. Otherwise stay.
    - ONE: accept&pop -> main<=in, ONE. accept&~pop -> skid<=in, FULL. ~accept&pop -> EMPTY. Otherwise hold.
    - FULL: `in_ready`=0. pop -> main<=skid, `s_valid`<=0, ONE. Otherwise hold.
  - Ordering is strict FIFO; no entry is duplicated or lost.
- `SKID_EN`=0:
  - `in_ready` = `(~m_valid | out_ready) & ~stall & ~flush`.
  - accept -> main<=in, valid 1. pop without accept -> `m_valid`<=0.
  - `occ` never exceeds 1.
- Throughput: one entry per cycle sustained when `out_ready`=1 and `stall`=0 in both modes.
- `occ` is registered and equals `m_valid + s_valid`.

Test Plan:
- Reset then stream: `rst_n` low 2 cycles, then `in_valid`=1 for 4 cycles with data 0x1..0x4 and `out_ready`=1.
  - Expect `out_valid` from cycle 1 with data 0x1,0x2,0x3,0x4 on consecutive cycles.
  - `occ` stays 1; `in_ready` stays 1.
- Back-pressure with `SKID_EN`=1: stream 0xA,0xB,0xC with `out_ready`=0 from cycle 1.
  - Expect 0xA in main and 0xB in skid, `occ`=2, `in_ready`=0, 0xC held upstream.
  - Raise `out_ready`: outputs 0xA,0xB,0xC in order, no loss or duplication.
- Flush while FULL: `occ`=2, assert `flush` with `in_valid`=1, `in_ctrl`=0xFF.
  - Expect `out_valid`=0 and `out_ctrl`=0 that cycle; next cycle `occ`=0, entry 0xFF dropped, `in_ready`=1.
- Stall: `occ`=1 holding ctrl 0x55, `stall`=1 for 3 cycles with `out_ready`=1.
  - Expect `out_valid`=0, `out_ctrl`=0, `in_ready`=0, `occ`=1 held.
  - After release, 0x55 emitted once.
- Async reset mid-operation: `occ`=2; drop `rst_n` between clock edges.
  - Expect `out_valid`=0 and `occ`=0 immediately, without waiting for `clk`.
  - After release, the first accepted entry emerges 1 cycle later.
- `SKID_EN`=0 pass-through: `out_ready`=0 with `occ`=1.
  - Expect `in_ready`=0; raise `out_ready` with `in_valid`=1 -> same-cycle pop and accept, `occ` stays 1.
